// File: rtl/pll_drp_sequencer.sv
// DRP reconfiguration sequencer for a secondary Spartan-6 PLL_ADV clocked from sys_clk.
// Holds the PLL in reset, read-modify-writes each queued register, then releases and waits for lock.
module pll_drp_sequencer #(
  parameter int RST_HOLD     = 8,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  input  logic [15:0] cmd_mask,
  input  logic        cmd_last,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [4:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        pll_rst,
  input  logic        pll_locked
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_HOLD,
    S_READ,
    S_RD_WAIT,
    S_WRITE,
    S_WR_WAIT,
    S_NEXT,
    S_RELEASE,
    S_LOCK_WAIT,
    S_ERROR
  } state_t;

  localparam logic [15:0] HOLD_INIT = 16'(RST_HOLD);
  localparam logic [15:0] DRDY_LIM  = 16'(DRDY_TIMEOUT - 1);
  localparam logic [15:0] LOCK_LIM  = 16'(LOCK_TIMEOUT - 1);

  localparam logic [1:0] ERR_RD_TMO   = 2'd1;
  localparam logic [1:0] ERR_WR_TMO   = 2'd2;
  localparam logic [1:0] ERR_LOCK_TMO = 2'd3;

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] data_q;
  logic [15:0] mask_q;
  logic        last_q;
  logic        accept;

  // Mask bit 1 keeps the bit read back from the PLL, 0 takes the new value.
  function automatic logic [15:0] merge_bits(input logic [15:0] old_v,
                                             input logic [15:0] new_v,
                                             input logic [15:0] keep);
    return (old_v & keep) | (new_v & ~keep);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  assign accept = cmd_valid && cmd_ready;

  // Command payload is plain data and needs no reset.
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      data_q <= cmd_data;
      mask_q <= cmd_mask;
      last_q <= cmd_last;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= S_IDLE;
      cnt       <= 16'd0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= 2'd0;
      drp_den   <= 1'b0;
      drp_dwe   <= 1'b0;
      drp_daddr <= 5'd0;
      drp_di    <= 16'd0;
      pll_rst   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            error     <= 1'b0;
            err_code  <= 2'd0;
            busy      <= 1'b1;
            pll_rst   <= 1'b1;
            cmd_ready <= 1'b0;
            drp_daddr <= cmd_addr;
            cnt       <= HOLD_INIT;
            state     <= S_RST_HOLD;
          end
        end

        S_RST_HOLD: begin
          if (cnt <= 16'd1) begin
            cnt     <= 16'd0;
            drp_den <= 1'b1;
            drp_dwe <= 1'b0;
            state   <= S_READ;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end

        S_READ: begin
          drp_den <= 1'b0;
          cnt     <= 16'd0;
          state   <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          if (drp_drdy) begin
            drp_di  <= merge_bits(drp_do, data_q, mask_q);
            drp_den <= 1'b1;
            drp_dwe <= 1'b1;
            state   <= S_WRITE;
          end else if (cnt >= DRDY_LIM) begin
            error    <= 1'b1;
            err_code <= ERR_RD_TMO;
            pll_rst  <= 1'b0;
            busy     <= 1'b0;
            state    <= S_ERROR;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        S_WRITE: begin
          drp_den <= 1'b0;
          drp_dwe <= 1'b0;
          cnt     <= 16'd0;
          state   <= S_WR_WAIT;
        end

        S_WR_WAIT: begin
          if (drp_drdy) begin
            if (last_q) begin
              pll_rst <= 1'b0;
              state   <= S_RELEASE;
            end else begin
              cmd_ready <= 1'b1;
              state     <= S_NEXT;
            end
          end else if (cnt >= DRDY_LIM) begin
            error    <= 1'b1;
            err_code <= ERR_WR_TMO;
            pll_rst  <= 1'b0;
            busy     <= 1'b0;
            state    <= S_ERROR;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        // PLL stays in reset while software prepares the next command.
        S_NEXT: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            drp_daddr <= cmd_addr;
            drp_den   <= 1'b1;
            drp_dwe   <= 1'b0;
            state     <= S_READ;
          end
        end

        S_RELEASE: begin
          cnt   <= 16'd0;
          state <= S_LOCK_WAIT;
        end

        S_LOCK_WAIT: begin
          if (pll_locked) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end else if (cnt >= LOCK_LIM) begin
            error    <= 1'b1;
            err_code <= ERR_LOCK_TMO;
            busy     <= 1'b0;
            state    <= S_ERROR;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        S_ERROR: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_drp_sequencer.sv
// Directed bench for pll_drp_sequencer with a behavioural PLL DRP model and a write scoreboard.
module tb_pll_drp_sequencer;

  localparam int RST_HOLD     = 8;
  localparam int DRDY_TIMEOUT = 64;
  localparam int LOCK_TIMEOUT = 100;
  localparam int DRDY_LAT     = 2;
  localparam logic [8:0] RST_STATUS = 9'b1_0_0_0_00_0_0_0;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic [15:0] cmd_mask;
  logic        cmd_last;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [4:0]  drp_daddr;
  logic        drp_den;
  logic        drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic        pll_rst;
  logic        pll_locked;

  always #5 sys_clk = ~sys_clk;

  pll_drp_sequencer #(
    .RST_HOLD(RST_HOLD),
    .DRDY_TIMEOUT(DRDY_TIMEOUT),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .cmd_mask(cmd_mask),
    .cmd_last(cmd_last),
    .busy(busy),
    .done(done),
    .error(error),
    .err_code(err_code),
    .drp_daddr(drp_daddr),
    .drp_den(drp_den),
    .drp_dwe(drp_dwe),
    .drp_di(drp_di),
    .drp_do(drp_do),
    .drp_drdy(drp_drdy),
    .pll_rst(pll_rst),
    .pll_locked(pll_locked)
  );

  int checks = 0;
  int errors = 0;
  int rd_count = 0;
  int wr_count = 0;
  int rst_rises = 0;
  int done_count = 0;
  int rst_run = 0;
  int last_rst_run = 0;
  int proto_viol = 0;

  logic [15:0] pll_mem [32];
  logic [15:0] shadow [32];
  logic [20:0] sb_q [$];
  logic        no_rd_drdy;
  logic        no_wr_drdy;
  logic        spur_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] status();
    return {cmd_ready, busy, done, error, err_code, drp_den, drp_dwe, pll_rst};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  // PLL DRP model: drdy DRDY_LAT cycles after DEN, reads return register contents.
  initial begin : pll_model
    int         pend;
    logic       pend_wr;
    logic [4:0] pend_addr;
    logic       prev_rst;
    logic [20:0] e;
    pend = 0;
    pend_wr = 1'b0;
    pend_addr = 5'd0;
    prev_rst = 1'b0;
    drp_drdy = 1'b0;
    drp_do = 16'd0;
    for (int i = 0; i < 32; i++) pll_mem[i] = 16'hABCD;
    forever begin
      @(posedge sys_clk);
      #1;
      drp_drdy = spur_req;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if (!pend_wr && !no_rd_drdy) begin
            drp_do = pll_mem[pend_addr];
            drp_drdy = 1'b1;
          end else if (pend_wr && !no_wr_drdy) begin
            drp_drdy = 1'b1;
          end
        end
      end
      if (drp_den) begin
        if (pend > 0) proto_viol++;
        pend = DRDY_LAT;
        pend_wr = drp_dwe;
        pend_addr = drp_daddr;
        if (drp_dwe) begin
          wr_count++;
          pll_mem[drp_daddr] = drp_di;
          chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_write", 32'({drp_daddr, drp_di}), 32'(e));
          end
        end else begin
          rd_count++;
        end
      end
      if (pll_rst && !prev_rst) rst_rises++;
      if (pll_rst) rst_run++;
      else if (prev_rst) begin
        last_rst_run = rst_run;
        rst_run = 0;
      end
      prev_rst = pll_rst;
      if (done) done_count++;
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 400 && !cmd_ready; i++) tick();
    chk("cmd_ready_seen", 32'(cmd_ready), 32'd1);
  endtask

  task automatic send_cmd(input logic [4:0] a, input logic [15:0] d, input logic [15:0] m,
                          input logic l, input logic exp_wr);
    logic [15:0] w;
    wait_ready();
    if (exp_wr) begin
      w = (shadow[a] & m) | (d & ~m);
      shadow[a] = w;
      sb_q.push_back({a, w});
    end
    cmd_addr = a;
    cmd_data = d;
    cmd_mask = m;
    cmd_last = l;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_release();
    for (int i = 0; i < 400 && !(!pll_rst && busy); i++) tick();
    chk("release_seen", 32'(!pll_rst && busy), 32'd1);
  endtask

  task automatic wait_error(output int n);
    n = 0;
    while (!error && n < 400) begin
      tick();
      n++;
    end
    chk("error_seen", 32'(error), 32'd1);
  endtask

  task automatic finish_lock();
    tick();
    tick();
    pll_locked = 1'b1;
    tick();
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_with_done", 32'(busy), 32'd0);
    pll_locked = 1'b0;
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(status()), 32'(RST_STATUS));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    int r0, w0, d0, q0, n;
    sys_rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = 5'd0;
    cmd_data = 16'd0;
    cmd_mask = 16'd0;
    cmd_last = 1'b0;
    pll_locked = 1'b0;
    no_rd_drdy = 1'b0;
    no_wr_drdy = 1'b0;
    spur_req = 1'b0;
    for (int i = 0; i < 32; i++) shadow[i] = 16'hABCD;

    repeat (3) tick();
    chk("rst_status", 32'(status()), 32'(RST_STATUS));
    chk("rst_daddr", 32'(drp_daddr), 32'd0);
    chk("rst_di", 32'(drp_di), 32'd0);
    sys_rst = 1'b0;
    tick();
    chk("idle_status", 32'(status()), 32'(RST_STATUS));

    // Single command
    send_cmd(5'h0A, 16'h1234, 16'hF000, 1'b1, 1'b1);
    chk("t1_accept", 32'({busy, pll_rst, cmd_ready}), 32'b110);
    wait_release();
    chk("t1_rst_len", 32'(last_rst_run >= RST_HOLD + 4), 32'd1);
    chk("t1_reg_0a", 32'(pll_mem[10]), 32'hA234);
    finish_lock();
    chk("t1_reads", 32'(rd_count), 32'd1);
    chk("t1_writes", 32'(wr_count), 32'd1);
    chk("t1_dones", 32'(done_count), 32'd1);

    // Batch of three with a gap before the last
    r0 = rd_count; w0 = wr_count; d0 = done_count; q0 = rst_rises;
    send_cmd(5'h01, 16'h00FF, 16'hFF00, 1'b0, 1'b1);
    send_cmd(5'h02, 16'h5A5A, 16'h0F0F, 1'b0, 1'b1);
    wait_ready();
    repeat (10) tick();
    chk("t2_gap_state", 32'({pll_rst, busy, cmd_ready}), 32'b111);
    send_cmd(5'h1F, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
    wait_release();
    finish_lock();
    chk("t2_reads", 32'(rd_count - r0), 32'd3);
    chk("t2_writes", 32'(wr_count - w0), 32'd3);
    chk("t2_rst_rises", 32'(rst_rises - q0), 32'd1);
    chk("t2_dones", 32'(done_count - d0), 32'd1);
    chk("t2_reg_02", 32'(pll_mem[2]), 32'h5B5D);

    // Read drdy never returned
    no_rd_drdy = 1'b1;
    r0 = rd_count; w0 = wr_count; d0 = done_count;
    send_cmd(5'h05, 16'h1111, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 100 && rd_count == r0; i++) tick();
    chk("t3_read_issued", 32'(rd_count - r0), 32'd1);
    wait_error(n);
    chk("t3_wait_len", 32'(n >= DRDY_TIMEOUT && n <= DRDY_TIMEOUT + 3), 32'd1);
    chk("t3_err_code", 32'(err_code), 32'd1);
    chk("t3_rst_busy", 32'({pll_rst, busy}), 32'b00);
    chk("t3_no_write", 32'(wr_count - w0), 32'd0);
    no_rd_drdy = 1'b0;
    tick();
    chk("t3_no_done", 32'(done_count - d0), 32'd0);

    // Write drdy never returned
    no_wr_drdy = 1'b1;
    d0 = done_count;
    send_cmd(5'h06, 16'h0F0F, 16'h00FF, 1'b1, 1'b1);
    wait_error(n);
    chk("t4_err_code", 32'(err_code), 32'd2);
    chk("t4_rst_busy", 32'({error, pll_rst, busy}), 32'b100);
    no_wr_drdy = 1'b0;
    tick();
    chk("t4_no_done", 32'(done_count - d0), 32'd0);

    // Lock never asserted
    d0 = done_count;
    send_cmd(5'h07, 16'h2222, 16'h0000, 1'b1, 1'b1);
    wait_release();
    wait_error(n);
    chk("t5_wait_len", 32'(n >= LOCK_TIMEOUT && n <= LOCK_TIMEOUT + 2), 32'd1);
    chk("t5_err_code", 32'(err_code), 32'd3);
    tick();
    tick();
    chk("t5_sticky", 32'({error, err_code, cmd_ready}), 32'b1111);
    chk("t5_no_done", 32'(done_count - d0), 32'd0);
    no_wr_drdy = 1'b1;
    w0 = wr_count;
    send_cmd(5'h08, 16'h3333, 16'h0000, 1'b0, 1'b1);
    chk("t5_err_cleared", 32'({error, err_code}), 32'd0);

    // Reset while waiting for write drdy
    for (int i = 0; i < 100 && wr_count == w0; i++) tick();
    chk("t6_write_issued", 32'(wr_count - w0), 32'd1);
    tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("t6_rst_status", 32'(status()), 32'(RST_STATUS));
    chk("t6_rst_addr_di", 32'({drp_daddr, drp_di}), 32'd0);
    no_wr_drdy = 1'b0;
    r0 = rd_count; w0 = wr_count;
    spur_req = 1'b1;
    tick();
    spur_req = 1'b0;
    tick();
    tick();
    chk("t6_spurious_status", 32'(status()), 32'(RST_STATUS));
    chk("t6_no_access", 32'((rd_count - r0) + (wr_count - w0)), 32'd0);

    chk("den_protocol", 32'(proto_viol), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
